vector_lane_sequencer: RTL and testbench
========================================

Name: vector_lane_sequencer

Overview:
Multi-cycle sequencer for vector instructions (ADDV, SUBV, MULV) issued from the Execute stage. It latches both source vectors and processes one lane at a time. Add and subtract lanes use an internal adder. Multiply lanes go to a shared scalar multiplier through a start/done handshake. While busy it stalls Fetch, Decode and Execute, then issues a single-cycle vector register write of the assembled result.

Parameters:
LANES, 4, number of vector lanes (power of 2, >=2)
WIDTH, 32, bits per lane

Ports:
clk  in  1  clock; all state updates on the rising edge
reset  in  1  synchronous, active-high reset
StartE  in  1  vector op present in Execute (already condition-gated)
VOpE  in  2  00 ADDV, 01 MULV, 10 SUBV, 11 illegal
VdE  in  4  destination vector register
SrcAE  in  LANES*WIDTH  source vector A; lane i = bits [i*WIDTH +: WIDTH]
SrcBE  in  LANES*WIDTH  source vector B, same packing
MulDone  in  1  multiplier result valid
MulResult  in  2*WIDTH  multiplier product
MulStart  out  1  one-cycle request to multiplier
MulA  out  WIDTH  multiplier operand A
MulB  out  WIDTH  multiplier operand B
StallSeq  out  1  stall F/D/E
Busy  out  1  state != IDLE
RegVWriteSeq  out  1  one-cycle vector register write enable
VdSeq  out  4  write destination
ResultV  out  LANES*WIDTH  assembled result vector

Behaviour:
- States: IDLE, ALU_LANE, MUL_REQ, MUL_WAIT, WRITE. Lane counter is clog2(LANES) bits.
- Reset: state IDLE, lane 0, latched operands and ResultV 0, VdSeq 0. MulStart, StallSeq, Busy and RegVWriteSeq are 0. MulA and MulB are 0.
- Legal start = StartE & VOpE != 11.
- IDLE + legal start: latch SrcAE, SrcBE, VOpE and VdE; clear ResultV; set lane = 0.
  - Next state is ALU_LANE for ADDV/SUBV, MUL_REQ for MULV.
- IDLE + illegal op: no action; state stays IDLE and StallSeq stays 0.
- StallSeq = (state==IDLE & legal start) | (state != IDLE). It is combinational from StartE/VOpE in IDLE.
- ALU_LANE: ResultV[lane] <= A[lane] + B[lane] (ADDV) or A[lane] - B[lane] (SUBV), modulo 2^WIDTH; no flags.
  - If lane == LANES-1, go to WRITE; otherwise lane++.
- MUL_REQ: MulStart = 1 for exactly one cycle, with MulA = A[lane] and MulB = B[lane]; go to MUL_WAIT.
- MUL_WAIT: MulStart = 0; MulA and MulB hold their values.
  - On MulDone: ResultV[lane] <= MulResult[WIDTH-1:0] (upper half discarded).
  - Then go to WRITE if this is the last lane, else lane++ and go to MUL_REQ.
  - MulDone is sampled only in MUL_WAIT, so it can arrive no earlier than 1 cycle after MulStart. Latency is unbounded; StallSeq holds throughout.
- WRITE: RegVWriteSeq = 1 and VdSeq = latched Vd for exactly one cycle; StallSeq = 1; next state IDLE.
  - ResultV stays valid until the next legal start.
- Latency with StartE at cycle 0:
  - ADDV/SUBV: lanes at cycles 1..LANES, write at LANES+1, IDLE at LANES+2. StallSeq is high for LANES+2 cycles.
  - MULV: each lane takes 1 + (multiplier latency) cycles, then one WRITE cycle.
- StartE while Busy: ignored; latched operands are unchanged.
- MulDone outside MUL_WAIT: ignored.
- Back-to-back ops: a legal start in the cycle after WRITE (state IDLE) is accepted normally.
- Reset during any state: next cycle all outputs return to reset values. Any in-flight multiplier result is ignored; no partial write is issued.

Test Plan:
- ADDV, LANES=4: A={1,2,3,4}, B={10,20,30,40} -> StallSeq high for 6 cycles; RegVWriteSeq pulses at cycle 5 with ResultV={11,22,33,44} and VdSeq=VdE.
- SUBV wrap: A lane0=0, B lane0=1 -> ResultV lane0=32'hFFFFFFFF; ADDV 32'hFFFFFFFF+2 -> 1.
- MULV with multiplier latency 1, 3, 0-then-5 per lane: A={2,3,0x10000,7}, B={5,4,0x10000,6} -> ResultV={10,12,0,42}. Exactly 4 MulStart pulses; StallSeq is never dropped before WRITE.
- VOpE=11 with StartE=1 -> StallSeq=0, Busy=0, no RegVWriteSeq. StartE pulses during an active ADDV -> result unaffected.
- Reset asserted in MUL_WAIT lane 2, then a late MulDone -> IDLE, all outputs 0, no RegVWriteSeq, MulDone ignored.
- ADDV then MULV with StartE in the first IDLE cycle after WRITE -> both writes are correct with no dropped start.

Source files
------------

// File: rtl/vector_lane_sequencer.sv
// Multi-cycle vector ADDV/SUBV/MULV sequencer: walks lanes one per step,
// shares an external scalar multiplier, then issues a one-cycle register write.

module vls_lane #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic             sub_i,
  output logic [WIDTH-1:0] y_o
);
  assign y_o = sub_i ? (a_i - b_i) : (a_i + b_i);
endmodule

module vector_lane_sequencer #(
  parameter int LANES = 4,
  parameter int WIDTH = 32
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   StartE,
  input  logic [1:0]             VOpE,
  input  logic [3:0]             VdE,
  input  logic [LANES*WIDTH-1:0] SrcAE,
  input  logic [LANES*WIDTH-1:0] SrcBE,
  input  logic                   MulDone,
  input  logic [2*WIDTH-1:0]     MulResult,
  output logic                   MulStart,
  output logic [WIDTH-1:0]       MulA,
  output logic [WIDTH-1:0]       MulB,
  output logic                   StallSeq,
  output logic                   Busy,
  output logic                   RegVWriteSeq,
  output logic [3:0]             VdSeq,
  output logic [LANES*WIDTH-1:0] ResultV
);
  localparam int LW = (LANES > 1) ? $clog2(LANES) : 1;

  typedef enum logic [2:0] {IDLE, ALU_LANE, MUL_REQ, MUL_WAIT, WRITE} state_t;
  typedef logic [LANES-1:0][WIDTH-1:0] vec_t;

  state_t           state_q, state_d;
  logic [LW-1:0]    lane_q, lane_d;
  vec_t             a_q, a_d, b_q, b_d, res_q, res_d, alu;
  logic [1:0]       op_q, op_d;
  logic [3:0]       vd_q, vd_d;
  logic [WIDTH-1:0] mula_q, mula_d, mulb_q, mulb_d;
  logic             legal, last, sub;

  assign legal = StartE && (VOpE != 2'b11);
  assign last  = (lane_q == LW'(LANES-1));
  assign sub   = (op_q == 2'b10);

  for (genvar i = 0; i < LANES; i++) begin : g_lane
    vls_lane #(.WIDTH(WIDTH)) u_lane (
      .a_i  (a_q[i]),
      .b_i  (b_q[i]),
      .sub_i(sub),
      .y_o  (alu[i])
    );
  end

  always_comb begin
    state_d = state_q;
    lane_d  = lane_q;
    a_d     = a_q;
    b_d     = b_q;
    res_d   = res_q;
    op_d    = op_q;
    vd_d    = vd_q;
    mula_d  = mula_q;
    mulb_d  = mulb_q;
    case (state_q)
      IDLE: if (legal) begin
        a_d     = SrcAE;
        b_d     = SrcBE;
        op_d    = VOpE;
        vd_d    = VdE;
        res_d   = '0;
        lane_d  = '0;
        state_d = (VOpE == 2'b01) ? MUL_REQ : ALU_LANE;
      end
      ALU_LANE: begin
        res_d[lane_q] = alu[lane_q];
        if (last) state_d = WRITE;
        else      lane_d  = lane_q + 1'b1;
      end
      MUL_REQ: begin
        // Capture operands so they stay stable while the multiplier works.
        mula_d  = a_q[lane_q];
        mulb_d  = b_q[lane_q];
        state_d = MUL_WAIT;
      end
      MUL_WAIT: if (MulDone) begin
        res_d[lane_q] = MulResult[WIDTH-1:0];
        if (last) state_d = WRITE;
        else begin
          lane_d  = lane_q + 1'b1;
          state_d = MUL_REQ;
        end
      end
      WRITE:   state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      lane_q  <= '0;
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
      op_q    <= '0;
      vd_q    <= '0;
      mula_q  <= '0;
      mulb_q  <= '0;
    end else begin
      state_q <= state_d;
      lane_q  <= lane_d;
      a_q     <= a_d;
      b_q     <= b_d;
      res_q   <= res_d;
      op_q    <= op_d;
      vd_q    <= vd_d;
      mula_q  <= mula_d;
      mulb_q  <= mulb_d;
    end
  end

  assign MulStart     = (state_q == MUL_REQ);
  assign MulA         = MulStart ? a_q[lane_q] : mula_q;
  assign MulB         = MulStart ? b_q[lane_q] : mulb_q;
  assign Busy         = (state_q != IDLE);
  assign StallSeq     = Busy || legal;
  assign RegVWriteSeq = (state_q == WRITE);
  assign VdSeq        = vd_q;
  assign ResultV      = res_q;
endmodule

// File: tb/tb_vector_lane_sequencer.sv
// Directed bench for vector_lane_sequencer: table of ALU ops plus hand-written
// multiply, reset-abort and back-to-back sequences.

module tb_vector_lane_sequencer;
  localparam int L = 4;
  localparam int W = 32;

  logic           clk = 1'b0;
  logic           reset;
  logic           StartE;
  logic [1:0]     VOpE;
  logic [3:0]     VdE;
  logic [L*W-1:0] SrcAE, SrcBE;
  logic           MulDone;
  logic [2*W-1:0] MulResult;
  logic           MulStart;
  logic [W-1:0]   MulA, MulB;
  logic           StallSeq, Busy, RegVWriteSeq;
  logic [3:0]     VdSeq;
  logic [L*W-1:0] ResultV;

  int ncmp = 0;
  int nbad = 0;
  int lat[L];

  typedef struct {
    logic [1:0]     op;
    logic [3:0]     vd;
    logic [L*W-1:0] a, b, exp;
    logic           pulse;
  } vec_t;
  vec_t tv[4];

  vector_lane_sequencer #(.LANES(L), .WIDTH(W)) dut (
    .clk(clk), .reset(reset), .StartE(StartE), .VOpE(VOpE), .VdE(VdE),
    .SrcAE(SrcAE), .SrcBE(SrcBE), .MulDone(MulDone), .MulResult(MulResult),
    .MulStart(MulStart), .MulA(MulA), .MulB(MulB), .StallSeq(StallSeq),
    .Busy(Busy), .RegVWriteSeq(RegVWriteSeq), .VdSeq(VdSeq), .ResultV(ResultV)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [L*W-1:0] act, input logic [L*W-1:0] exp);
    ncmp++;
    if (act !== exp) begin
      nbad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  // Entered at posedge+1 of the start cycle; returns at the WRITE cycle's sample point.
  task automatic run_alu(input vec_t v);
    StartE = 1'b1; VOpE = v.op; VdE = v.vd; SrcAE = v.a; SrcBE = v.b;
    #4;
    chk("alu_stall_c0", StallSeq, 1);
    chk("alu_busy_c0", Busy, 0);
    for (int c = 1; c <= L + 1; c++) begin
      tick();
      if (v.pulse && c <= L) begin
        StartE = 1'b1; VOpE = 2'b01; SrcAE = ~v.a; SrcBE = $urandom; VdE = ~v.vd;
      end else StartE = 1'b0;
      #4;
      chk("alu_stall", StallSeq, 1);
      chk("alu_busy", Busy, 1);
      chk("alu_wr", RegVWriteSeq, (c == L + 1));
    end
    chk("alu_result", ResultV, v.exp);
    chk("alu_vd", VdSeq, v.vd);
  endtask

  // Multiplier model; per-lane extra wait cycles from lat[]. abort_at >= 0
  // returns right after that lane's MulStart is seen.
  task automatic mul_op(input logic [L*W-1:0] a, input logic [L*W-1:0] b,
                        input logic [3:0] vd, input logic [L*W-1:0] exp, input int abort_at);
    logic [2*W-1:0] prod;
    int  cnt, idx;
    bit  pend, wrote, drop, dn;
    StartE = 1'b1; VOpE = 2'b01; VdE = vd; SrcAE = a; SrcBE = b;
    #4;
    chk("mul_stall_c0", StallSeq, 1);
    pend = 0; idx = 0; wrote = 0; drop = 0; cnt = 0; prod = '0;
    for (int c = 0; c < 200 && !wrote; c++) begin
      tick();
      StartE = 1'b0;
      dn = 0;
      if (pend && cnt == 0) begin
        MulDone = 1'b1; MulResult = prod; pend = 0; dn = 1;
      end else if (pend) begin
        MulDone = 1'b0; MulResult = {$urandom, $urandom}; cnt--;
      end else begin
        // Spurious done outside MUL_WAIT must be ignored.
        MulDone = 1'b1; MulResult = {$urandom, $urandom};
      end
      #4;
      if (!StallSeq) drop = 1;
      if (dn) chk("mula_hold", MulA, a[(idx-1)*W +: W]);
      if (MulStart) begin
        chk("mula", MulA, a[idx*W +: W]);
        chk("mulb", MulB, b[idx*W +: W]);
        prod = {32'b0, a[idx*W +: W]} * {32'b0, b[idx*W +: W]};
        pend = 1; cnt = lat[idx]; idx++;
        if (idx == abort_at + 1) return;
      end
      if (RegVWriteSeq) begin
        wrote = 1;
        chk("mul_result", ResultV, exp);
        chk("mul_vd", VdSeq, vd);
      end
    end
    MulDone = 1'b0;
    chk("mul_wrote", wrote, 1);
    chk("mul_starts", idx, L);
    chk("mul_stall_drop", drop, 0);
  endtask

  initial begin
    tv[0] = '{2'b00, 4'd5,  {32'd4, 32'd3, 32'd2, 32'd1}, {32'd40, 32'd30, 32'd20, 32'd10},
              {32'd44, 32'd33, 32'd22, 32'd11}, 1'b0};
    tv[1] = '{2'b10, 4'd9,  {32'd100, 32'd7, 32'h80000000, 32'd0}, {32'd1, 32'd7, 32'd1, 32'd1},
              {32'd99, 32'd0, 32'h7FFFFFFF, 32'hFFFFFFFF}, 1'b0};
    tv[2] = '{2'b00, 4'd15, {32'd0, 32'd0, 32'h12345678, 32'hFFFFFFFF}, {32'd0, 32'd0, 32'h11111111, 32'd2},
              {32'd0, 32'd0, 32'h23456789, 32'd1}, 1'b1};
    tv[3] = '{2'b10, 4'd0,  {32'd10, 32'd20, 32'd30, 32'd5}, {32'd3, 32'd25, 32'd30, 32'd6},
              {32'd7, 32'hFFFFFFFB, 32'd0, 32'hFFFFFFFF}, 1'b1};

    reset = 1'b1; StartE = 1'b0; VOpE = '0; VdE = '0; SrcAE = '0; SrcBE = '0;
    MulDone = 1'b0; MulResult = '0;
    tick(); tick();
    reset = 1'b0;
    #4;
    chk("rst_busy", Busy, 0);
    chk("rst_stall", StallSeq, 0);
    chk("rst_wr", RegVWriteSeq, 0);
    chk("rst_mulstart", MulStart, 0);
    chk("rst_mula", MulA, 0);
    chk("rst_mulb", MulB, 0);
    chk("rst_result", ResultV, 0);
    chk("rst_vd", VdSeq, 0);

    // Illegal op with a stray MulDone in IDLE.
    tick();
    StartE = 1'b1; VOpE = 2'b11; VdE = 4'd3; MulDone = 1'b1;
    #4;
    chk("ill_stall", StallSeq, 0);
    chk("ill_busy", Busy, 0);
    chk("ill_mulstart", MulStart, 0);
    tick();
    StartE = 1'b0; MulDone = 1'b0;
    #4;
    chk("ill_busy_n", Busy, 0);
    chk("ill_wr", RegVWriteSeq, 0);
    chk("ill_result", ResultV, 0);

    for (int i = 0; i < 4; i++) begin
      tick();
      run_alu(tv[i]);
      tick();
      StartE = 1'b0;
      #4;
      chk("alu_idle_busy", Busy, 0);
      chk("alu_idle_stall", StallSeq, 0);
      chk("alu_idle_wr", RegVWriteSeq, 0);
      chk("alu_hold_result", ResultV, tv[i].exp);
    end

    // MULV with varying multiplier latency.
    lat[0] = 1; lat[1] = 3; lat[2] = 0; lat[3] = 5;
    tick();
    mul_op({32'd7, 32'h10000, 32'd3, 32'd2}, {32'd6, 32'h10000, 32'd4, 32'd5}, 4'd12,
           {32'd42, 32'd0, 32'd12, 32'd10}, -1);
    tick();
    MulDone = 1'b0;
    #4;
    chk("mul_idle_busy", Busy, 0);

    // Back-to-back: ADDV, then MULV started in the first IDLE cycle after WRITE.
    tick();
    run_alu(tv[0]);
    tick();
    mul_op({32'd1, 32'd2, 32'd3, 32'd4}, {32'd9, 32'd9, 32'd9, 32'hFFFFFFFF}, 4'd7,
           {32'd9, 32'd18, 32'd27, 32'hFFFFFFFC}, -1);
    tick();
    MulDone = 1'b0;
    #4;
    chk("b2b_idle_busy", Busy, 0);

    // Reset while waiting on lane 2's product, then a late MulDone.
    lat[0] = 0; lat[1] = 0; lat[2] = 0; lat[3] = 0;
    tick();
    mul_op({32'd1, 32'd2, 32'd3, 32'd4}, {32'd5, 32'd6, 32'd7, 32'd8}, 4'd11, '0, 2);
    tick();
    reset = 1'b1; MulDone = 1'b0;
    #4;
    chk("abort_busy_pre", Busy, 1);
    tick();
    reset = 1'b0; MulDone = 1'b1; MulResult = 64'h1234;
    #4;
    chk("abort_busy", Busy, 0);
    chk("abort_stall", StallSeq, 0);
    chk("abort_mulstart", MulStart, 0);
    chk("abort_mula", MulA, 0);
    chk("abort_mulb", MulB, 0);
    chk("abort_result", ResultV, 0);
    chk("abort_vd", VdSeq, 0);
    chk("abort_wr", RegVWriteSeq, 0);
    for (int c = 0; c < 4; c++) begin
      tick();
      MulDone = c[0];
      #4;
      chk("abort_late_wr", RegVWriteSeq, 0);
      chk("abort_late_busy", Busy, 0);
    end
    MulDone = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nbad);
    $finish;
  end
endmodule
